// File: rtl/bp_cce_mem_mux_pkg.sv
// Shared helpers for the CCE-to-memory multiplexer and its tag FIFO.
package bp_cce_mem_mux_pkg;

    // Index width for a set of n items, never narrower than one bit.
    function automatic int lgWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_cce_mem_mux_tag_fifo.sv
// In-order FIFO of channel ids for commands in flight to memory.
// A push and a pop may land in the same cycle, including when the FIFO is full.
module bp_cce_mem_mux_tag_fifo
    import bp_cce_mem_mux_pkg::*;
#(
    parameter int depth_p = 8,
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PtrW = lgWidth(depth_p);
    localparam int CntW = $clog2(depth_p + 1);

    logic [width_p-1:0] mem_q [depth_p];
    logic [PtrW-1:0]    rdPtr_q, rdPtr_d;
    logic [PtrW-1:0]    wrPtr_q, wrPtr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               pushEn;
    logic               popEn;

    assign full_o  = (count_q == CntW'(depth_p));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rdPtr_q];
    assign popEn   = pop_i & ~empty_o;
    assign pushEn  = push_i & (~full_o | popEn);

    // Advance the read/write pointers with wrap at depth and track occupancy.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (popEn) begin
            rdPtr_d = (rdPtr_q == PtrW'(depth_p - 1)) ? '0 : rdPtr_q + 1'b1;
        end
        if (pushEn) begin
            wrPtr_d = (wrPtr_q == PtrW'(depth_p - 1)) ? '0 : wrPtr_q + 1'b1;
        end
        if (pushEn && !popEn) begin
            count_d = count_q + 1'b1;
        end else if (popEn && !pushEn) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the occupancy count says which entries are live.
    always_ff @(posedge clk_i) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bp_cce_mem_mux.sv
// N CCEs share one CCE-MEM port: one buffered command per channel, round-robin
// issue, and in-order responses steered back by a FIFO of issuing channel ids.
// Per-channel credits bound how many commands each CCE may have in flight.
module bp_cce_mem_mux
    import bp_cce_mem_mux_pkg::*;
#(
    parameter int num_cce_p         = 2,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 8,
    parameter int credits_p         = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_cce_p*msg_width_p-1:0] mem_cmd_i,
    input  logic [num_cce_p-1:0]             mem_cmd_v_i,
    output logic [num_cce_p-1:0]             mem_cmd_ready_o,
    output logic [num_cce_p*msg_width_p-1:0] mem_resp_o,
    output logic [num_cce_p-1:0]             mem_resp_v_o,
    input  logic [num_cce_p-1:0]             mem_resp_yumi_i,
    output logic [msg_width_p-1:0]           mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_i,
    input  logic [msg_width_p-1:0]           mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_yumi_o,
    output logic                             error_o
);

    localparam int lg_num_cce_lp = lgWidth(num_cce_p);
    localparam int CredW         = $clog2(credits_p + 1);

    logic [num_cce_p-1:0]     bufFull;
    logic [num_cce_p-1:0]     cmdReady;
    logic [num_cce_p-1:0]     accept;
    logic [num_cce_p-1:0]     creditRet;
    logic [msg_width_p-1:0]   bufData [num_cce_p];
    logic [lg_num_cce_lp-1:0] grant;
    logic [lg_num_cce_lp-1:0] rrPtr_q, rrPtr_d;
    logic [lg_num_cce_lp-1:0] tagHead;
    logic                     tagFull;
    logic                     tagEmpty;
    logic                     tagPop;
    logic                     issue;
    logic                     error_q;

    // Responses are owned by the channel at the head of the tag FIFO; an
    // orphan response (no tag) is swallowed so memory never stalls on it.
    assign tagPop          = reset_n_i & mem_resp_v_i & ~tagEmpty & mem_resp_yumi_i[tagHead];
    assign mem_resp_yumi_o = reset_n_i & mem_resp_v_i & (tagEmpty | mem_resp_yumi_i[tagHead]);
    assign mem_resp_o      = {num_cce_p{mem_resp_i}};

    // A pop in the same cycle frees a slot, so a full tag FIFO need not block issue.
    assign issue           = reset_n_i & mem_cmd_ready_i & (|bufFull) & (~tagFull | tagPop);
    assign mem_cmd_v_o     = issue;
    assign mem_cmd_o       = bufData[grant];
    assign mem_cmd_ready_o = cmdReady;
    assign error_o         = error_q;

    // Round-robin pick: first full buffer at or after the pointer.
    always_comb begin
        logic                   found;
        logic [lg_num_cce_lp:0] sum;
        grant = rrPtr_q;
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < num_cce_p; i++) begin
            sum = {1'b0, rrPtr_q} + (lg_num_cce_lp + 1)'(i);
            if (sum >= (lg_num_cce_lp + 1)'(num_cce_p)) begin
                sum = sum - (lg_num_cce_lp + 1)'(num_cce_p);
            end
            if (!found && bufFull[sum[lg_num_cce_lp-1:0]]) begin
                grant = sum[lg_num_cce_lp-1:0];
                found = 1'b1;
            end
        end
        rrPtr_d = rrPtr_q;
        if (issue) begin
            rrPtr_d = (grant == lg_num_cce_lp'(num_cce_p - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Fan the response valid out to the head channel only.
    always_comb begin
        mem_resp_v_o = '0;
        if (reset_n_i && mem_resp_v_i && !tagEmpty) begin
            mem_resp_v_o[tagHead] = 1'b1;
        end
    end

    // Arbitration pointer and the sticky orphan-response flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rrPtr_q <= '0;
            error_q <= 1'b0;
        end else begin
            rrPtr_q <= rrPtr_d;
            if (mem_resp_v_i && tagEmpty) begin
                error_q <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < num_cce_p; k++) begin : gChan
        logic                   full_q;
        logic [msg_width_p-1:0] data_q;
        logic [CredW-1:0]       credit_q;

        assign cmdReady[k]  = reset_n_i & ~full_q & (credit_q != '0);
        assign accept[k]    = cmdReady[k] & mem_cmd_v_i[k];
        assign creditRet[k] = tagPop & (tagHead == lg_num_cce_lp'(k));
        assign bufFull[k]   = full_q;
        assign bufData[k]   = data_q;

        // One-entry command buffer: filled on accept, emptied when granted.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                full_q <= 1'b0;
                data_q <= '0;
            end else if (accept[k]) begin
                full_q <= 1'b1;
                data_q <= mem_cmd_i[k*msg_width_p +: msg_width_p];
            end else if (issue && (grant == lg_num_cce_lp'(k))) begin
                full_q <= 1'b0;
            end
        end

        // Credits drop on accept, come back when this channel's response is taken.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                credit_q <= CredW'(credits_p);
            end else if (accept[k] && !creditRet[k]) begin
                credit_q <= credit_q - 1'b1;
            end else if (creditRet[k] && !accept[k]) begin
                credit_q <= credit_q + 1'b1;
            end
        end

        assert property (@(posedge clk_i) disable iff (!reset_n_i)
            !(creditRet[k] && !accept[k] && (credit_q == CredW'(credits_p))));
        assert property (@(posedge clk_i) disable iff (!reset_n_i)
            !(accept[k] && !creditRet[k] && (credit_q == '0)));
    end

    bp_cce_mem_mux_tag_fifo #(
        .depth_p (max_outstanding_p),
        .width_p (lg_num_cce_lp)
    ) tagFifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (issue),
        .data_i    (grant),
        .pop_i     (tagPop),
        .data_o    (tagHead),
        .full_o    (tagFull),
        .empty_o   (tagEmpty)
    );

endmodule

// File: tb/tb_bp_cce_mem_mux.sv
// Directed vector bench for bp_cce_mem_mux: two channels, 16-bit messages,
// a 4-deep tag FIFO and 4 credits per channel so tag-full is reachable.
module tb_bp_cce_mem_mux;

    localparam int NumCce  = 2;
    localparam int MsgW    = 16;
    localparam int MaxOut  = 4;
    localparam int Credits = 4;

    logic                   clk;
    logic                   resetN;
    logic [NumCce*MsgW-1:0] memCmdIn;
    logic [NumCce-1:0]      memCmdVIn;
    logic [NumCce-1:0]      memCmdReadyOut;
    logic [NumCce*MsgW-1:0] memRespOut;
    logic [NumCce-1:0]      memRespVOut;
    logic [NumCce-1:0]      memRespYumiIn;
    logic [MsgW-1:0]        memCmdOut;
    logic                   memCmdVOut;
    logic                   memCmdReadyIn;
    logic [MsgW-1:0]        memRespIn;
    logic                   memRespVIn;
    logic                   memRespYumiOut;
    logic                   errorOut;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rstN;
        logic [1:0]  cmdV;
        logic [15:0] cmd1;
        logic [15:0] cmd0;
        logic        rdyI;
        logic        respV;
        logic [1:0]  yumi;
        logic [15:0] resp;
        logic [1:0]  eRdy;
        logic        eCmdV;
        logic [15:0] eCmdO;
        logic [1:0]  eRespV;
        logic        eYumi;
        logic        eErr;
    } vec_t;

    vec_t vecs[$];

    bp_cce_mem_mux #(
        .num_cce_p         (NumCce),
        .msg_width_p       (MsgW),
        .max_outstanding_p (MaxOut),
        .credits_p         (Credits)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (resetN),
        .mem_cmd_i       (memCmdIn),
        .mem_cmd_v_i     (memCmdVIn),
        .mem_cmd_ready_o (memCmdReadyOut),
        .mem_resp_o      (memRespOut),
        .mem_resp_v_o    (memRespVOut),
        .mem_resp_yumi_i (memRespYumiIn),
        .mem_cmd_o       (memCmdOut),
        .mem_cmd_v_o     (memCmdVOut),
        .mem_cmd_ready_i (memCmdReadyIn),
        .mem_resp_i      (memRespIn),
        .mem_resp_v_i    (memRespVIn),
        .mem_resp_yumi_o (memRespYumiOut),
        .error_o         (errorOut)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(
        input logic rstN, input logic [1:0] cmdV, input logic [15:0] cmd1, input logic [15:0] cmd0,
        input logic rdyI, input logic respV, input logic [1:0] yumi, input logic [15:0] resp,
        input logic [1:0] eRdy, input logic eCmdV, input logic [15:0] eCmdO,
        input logic [1:0] eRespV, input logic eYumi, input logic eErr);
        vec_t v;
        v.rstN = rstN;  v.cmdV = cmdV;   v.cmd1 = cmd1;     v.cmd0 = cmd0;
        v.rdyI = rdyI;  v.respV = respV; v.yumi = yumi;     v.resp = resp;
        v.eRdy = eRdy;  v.eCmdV = eCmdV; v.eCmdO = eCmdO;   v.eRespV = eRespV;
        v.eYumi = eYumi; v.eErr = eErr;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        resetN        = v.rstN;
        memCmdVIn     = v.cmdV;
        memCmdIn      = {v.cmd1, v.cmd0};
        memCmdReadyIn = v.rdyI;
        memRespVIn    = v.respV;
        memRespYumiIn = v.yumi;
        memRespIn     = v.resp;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        resetN        = 1'b0;
        memCmdIn      = '0;
        memCmdVIn     = '0;
        memCmdReadyIn = 1'b0;
        memRespIn     = '0;
        memRespVIn    = 1'b0;
        memRespYumiIn = '0;

        //               rst cmdV   cmd1     cmd0     rdy rV yumi  resp       eRdy  eCV eCmdO    eRV   eY eErr
        vecs.push_back(mkVec(0, 2'b11, 16'h0000, 16'h0000, 1, 1, 2'b11, 16'hEEEE, 2'b00, 0, 16'h0000, 2'b00, 0, 0));
        // single command round trip on channel 0
        vecs.push_back(mkVec(1, 2'b01, 16'h0000, 16'hA0A0, 1, 0, 2'b00, 16'h0000, 2'b11, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 2'b00, 16'h0000, 2'b10, 1, 16'hA0A0, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b00, 16'h5151, 2'b11, 0, 16'h0000, 2'b01, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b01, 16'h5151, 2'b11, 0, 16'h0000, 2'b01, 1, 0));
        vecs.push_back(mkVec(0, 2'b11, 16'h0000, 16'h0000, 1, 1, 2'b11, 16'hEEEE, 2'b00, 0, 16'h0000, 2'b00, 0, 0));
        // both channels streaming: issue alternates 0,1,0,1
        vecs.push_back(mkVec(1, 2'b11, 16'h1001, 16'h0001, 1, 0, 2'b00, 16'h0000, 2'b11, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b11, 16'h1002, 16'h0002, 1, 0, 2'b00, 16'h0000, 2'b00, 1, 16'h0001, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b11, 16'h1002, 16'h0002, 1, 0, 2'b00, 16'h0000, 2'b01, 1, 16'h1001, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b11, 16'h1002, 16'h0003, 1, 0, 2'b00, 16'h0000, 2'b10, 1, 16'h0002, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 2'b00, 16'h0000, 2'b01, 1, 16'h1002, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b11, 16'h1111, 2'b11, 0, 16'h0000, 2'b01, 1, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b10, 16'h2222, 2'b11, 0, 16'h0000, 2'b10, 1, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b01, 16'h3333, 2'b11, 0, 16'h0000, 2'b01, 1, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b01, 16'h4444, 2'b11, 0, 16'h0000, 2'b10, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b10, 16'h4444, 2'b11, 0, 16'h0000, 2'b10, 1, 0));
        // orphan response: dropped, error sticks
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b00, 16'hDEAD, 2'b11, 0, 16'h0000, 2'b00, 1, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 2'b00, 16'h0000, 2'b11, 0, 16'h0000, 2'b00, 0, 1));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 2'b00, 16'h0000, 2'b11, 0, 16'h0000, 2'b00, 0, 1));
        vecs.push_back(mkVec(0, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b00, 16'hEEEE, 2'b00, 0, 16'h0000, 2'b00, 0, 0));
        // channel 0 exhausts its credits; one response restores one
        vecs.push_back(mkVec(1, 2'b01, 16'h0000, 16'h0031, 1, 0, 2'b00, 16'h0000, 2'b11, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b01, 16'h0000, 16'h0032, 1, 0, 2'b00, 16'h0000, 2'b10, 1, 16'h0031, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b01, 16'h0000, 16'h0032, 1, 0, 2'b00, 16'h0000, 2'b11, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b01, 16'h0000, 16'h0033, 1, 0, 2'b00, 16'h0000, 2'b10, 1, 16'h0032, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b01, 16'h0000, 16'h0033, 1, 0, 2'b00, 16'h0000, 2'b11, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b01, 16'h0000, 16'h0034, 1, 0, 2'b00, 16'h0000, 2'b10, 1, 16'h0033, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b01, 16'h0000, 16'h0034, 1, 0, 2'b00, 16'h0000, 2'b11, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b01, 16'h0000, 16'h0035, 1, 0, 2'b00, 16'h0000, 2'b10, 1, 16'h0034, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b01, 16'h0000, 16'h0035, 1, 0, 2'b00, 16'h0000, 2'b10, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b01, 16'h7777, 2'b10, 0, 16'h0000, 2'b01, 1, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 2'b00, 16'h0000, 2'b11, 0, 16'h0000, 2'b00, 0, 0));
        // tag FIFO full holds a command until a response pops in the same cycle
        vecs.push_back(mkVec(1, 2'b10, 16'h0041, 16'h0000, 1, 0, 2'b00, 16'h0000, 2'b11, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 2'b00, 16'h0000, 2'b01, 1, 16'h0041, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b10, 16'h0042, 16'h0000, 1, 0, 2'b00, 16'h0000, 2'b11, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 2'b00, 16'h0000, 2'b01, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 0, 0, 2'b00, 16'h0000, 2'b01, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b01, 16'h8888, 2'b01, 1, 16'h0042, 2'b01, 1, 0));
        vecs.push_back(mkVec(1, 2'b01, 16'h0000, 16'h0043, 1, 0, 2'b00, 16'h0000, 2'b11, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 2'b00, 16'h0000, 2'b10, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 0, 1, 2'b11, 16'h9999, 2'b10, 0, 16'h0000, 2'b01, 1, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b11, 16'hAAAA, 2'b10, 1, 16'h0043, 2'b01, 1, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 0, 1, 2'b11, 16'hBBBB, 2'b11, 0, 16'h0000, 2'b10, 1, 0));
        // reset with three outstanding: stale response afterwards is an orphan
        vecs.push_back(mkVec(1, 2'b10, 16'h0061, 16'h0000, 0, 0, 2'b00, 16'h0000, 2'b11, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 2'b00, 16'h0000, 2'b01, 1, 16'h0061, 2'b00, 0, 0));
        vecs.push_back(mkVec(0, 2'b11, 16'h0000, 16'h0000, 1, 1, 2'b11, 16'hCCCC, 2'b00, 0, 16'h0000, 2'b00, 0, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b01, 16'hCCCC, 2'b11, 0, 16'h0000, 2'b00, 1, 0));
        vecs.push_back(mkVec(1, 2'b00, 16'h0000, 16'h0000, 1, 0, 2'b00, 16'h0000, 2'b11, 0, 16'h0000, 2'b00, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d cmd_ready", i), 32'(memCmdReadyOut), 32'(vecs[i].eRdy));
            checkOutput($sformatf("v%0d cmd_v", i), 32'(memCmdVOut), 32'(vecs[i].eCmdV));
            if (vecs[i].eCmdV) begin
                checkOutput($sformatf("v%0d cmd_data", i), 32'(memCmdOut), 32'(vecs[i].eCmdO));
            end
            checkOutput($sformatf("v%0d resp_v", i), 32'(memRespVOut), 32'(vecs[i].eRespV));
            checkOutput($sformatf("v%0d resp_yumi", i), 32'(memRespYumiOut), 32'(vecs[i].eYumi));
            checkOutput($sformatf("v%0d error", i), 32'(errorOut), 32'(vecs[i].eErr));
            checkOutput($sformatf("v%0d resp_data", i), 32'(memRespOut), {vecs[i].resp, vecs[i].resp});
        end

        // Asynchronous reset between clock edges clears a pending issue and the error flag.
        @(negedge clk);
        memCmdVIn     = 2'b01;
        memCmdIn      = {16'h0000, 16'h00F1};
        memCmdReadyIn = 1'b0;
        memRespVIn    = 1'b0;
        memRespYumiIn = 2'b00;
        @(negedge clk);
        memCmdVIn     = 2'b00;
        memCmdReadyIn = 1'b1;
        #1;
        checkOutput("async pre cmd_v", 32'(memCmdVOut), 32'd1);
        checkOutput("async pre cmd_data", 32'(memCmdOut), 32'h00F1);
        checkOutput("async pre error", 32'(errorOut), 32'd1);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("async cmd_v", 32'(memCmdVOut), 32'd0);
        checkOutput("async error", 32'(errorOut), 32'd0);
        checkOutput("async cmd_ready", 32'(memCmdReadyOut), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        #1;
        checkOutput("post reset cmd_v", 32'(memCmdVOut), 32'd0);
        checkOutput("post reset cmd_ready", 32'(memCmdReadyOut), 32'b11);

        // Full credit budget after reset: exactly four commands on channel 0.
        for (int n = 0; n < Credits; n++) begin
            @(negedge clk);
            memCmdVIn = 2'b01;
            memCmdIn  = {16'h0000, 16'(16'h0050 + n)};
            #1;
            checkOutput($sformatf("credit %0d ready", n), 32'(memCmdReadyOut[0]), 32'd1);
            @(negedge clk);
            memCmdVIn = 2'b00;
            #1;
            checkOutput($sformatf("credit %0d issue", n), 32'(memCmdOut), 32'(16'h0050 + n));
        end
        @(negedge clk);
        #1;
        checkOutput("credits exhausted ready", 32'(memCmdReadyOut), 32'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
